pipe_skid_stage: RTL and testbench

// - Parametrised pipeline register stage that replaces the fixed-width IF/ID and ID/EX flip-flop stages.
// - Adds a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is registered
//   and throughput stays at 1 word/clk under backpressure.
// - Adds per-stage hold and flush (flush refills the output with a bubble value), occupancy

---
 rtl/pipe_skid_stage.sv | 145 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with a 2-entry skid buffer, hold/flush control,
// occupancy reporting and a saturating stall counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i   upstream handshake and payload
//   m_valid_o/m_ready_i/m_data_o   downstream handshake and registered payload
//   hold_i, flush_i                stage freeze / discard requests
//   clr_stat_i                     clear the stall counter
//   occupancy_o                    words held (0, 1 or 2)
//   stall_cnt_o                    saturating count of stalled cycles
module pipe_skid_stage #(
    parameter int unsigned       DATA_W      = 64,
    parameter logic [DATA_W-1:0] FLUSH_VALUE = 64'h0000_0013,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              clr_stat_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  cnt_q;

    logic main_valid;
    logic skid_valid;
    logic do_in;
    logic do_out;
    logic load_main;
    logic main_from_skid;
    logic load_skid;
    logic stall;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    // s_ready_o depends only on registered state and hold_i,
    // never on m_ready_i.
    assign s_ready_o = ~skid_valid & ~hold_i;
    assign m_valid_o = main_valid & ~hold_i;

    assign do_in  = s_valid_i & s_ready_o & ~flush_i & ~hold_i;
    assign do_out = main_valid & m_ready_i & ~hold_i;
    assign stall  = main_valid & ~(m_ready_i & ~hold_i);

    always_comb begin
        state_n        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (do_in) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (do_in && !do_out) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (do_in && do_out) begin
                    load_main = 1'b1;
                end else if (do_out) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (do_out) begin
                    state_n        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= FLUSH_VALUE;
        end else if (flush_i) begin
            // An out-transfer in this cycle still completes downstream;
            // everything left in the stage is dropped.
            state_q <= EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= FLUSH_VALUE;
        end else begin
            state_q <= state_n;
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : s_data_i;
            end
            if (load_skid) begin
                skid_q <= s_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_stat_i) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        occupancy_o = 2'd0;
        unique case (state_q)
            EMPTY:   occupancy_o = 2'd0;
            ONE:     occupancy_o = 2'd1;
            FULL:    occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    assign m_data_o    = main_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_pipe_skid_stage;

    localparam int          W  = 64;
    localparam int          CW = 4;
    localparam logic [63:0] FV = 64'h13;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         hold;
    logic         flush;
    logic         clr;
    logic [1:0]   occ;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W      (W),
        .FLUSH_VALUE (FV),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .hold_i      (hold),
        .flush_i     (flush),
        .clr_stat_i  (clr),
        .occupancy_o (occ),
        .stall_cnt_o (cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of held words, the last shown payload
    // and a saturating counter.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    int           m_cnt;
    bit           model_ok = 0;
    int           sz;
    bit           in_x;
    bit           out_x;
    bit           stall_x;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_last   = FV;
            m_cnt    = 0;
            model_ok = 1;
        end else if (model_ok) begin
            sz      = mq.size();
            stall_x = (sz > 0) && !(m_ready && !hold);
            in_x    = s_valid && (sz < 2) && !hold && !flush;
            out_x   = (sz > 0) && m_ready && !hold;
            if (clr) m_cnt = 0;
            else if (stall_x && m_cnt < (1 << CW) - 1) m_cnt++;
            if (flush) begin
                mq.delete();
                m_last = FV;
            end else begin
                if (out_x) void'(mq.pop_front());
                if (in_x) mq.push_back(s_data);
                if (mq.size() > 0) m_last = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_valid", m_valid, (mq.size() > 0 && !hold));
            chk("s_ready", s_ready, (mq.size() < 2 && !hold));
            chk("occupancy", occ, mq.size());
            chk("m_data", m_data, m_last);
            chk("stall_cnt", cnt, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        clr     = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_occ", occ, 0);
        chk("rst_m_data", m_data, 64'h13);
        chk("rst_cnt", cnt, 0);

        // streaming
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 64'(i);
            step();
            chk("stream_data", m_data, 64'(i));
            chk("stream_occ", occ, 1);
            chk("stream_ready", s_ready, 1);
        end
        s_valid = 1'b0;
        step();
        chk("stream_drain_occ", occ, 0);
        chk("stream_hold_data", m_data, 64'h8);

        // backpressure
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'hA;
        step();
        s_data = 64'hB;
        step();
        chk("bp_occ_full", occ, 2);
        chk("bp_ready_low", s_ready, 0);
        s_data = 64'hC;
        step();
        chk("bp_c_waits", occ, 2);
        chk("bp_head_a", m_data, 64'hA);
        m_ready = 1'b1;
        step();
        chk("bp_head_b", m_data, 64'hB);
        chk("bp_occ_one", occ, 1);
        step();
        chk("bp_head_c", m_data, 64'hC);
        s_valid = 1'b0;
        step();
        chk("bp_drained", occ, 0);

        // flush while full with an incoming word
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h21;
        step();
        s_data = 64'h22;
        step();
        s_data = 64'h23;
        flush  = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("fl_occ", occ, 0);
        chk("fl_m_valid", m_valid, 0);
        chk("fl_m_data", m_data, 64'h13);
        m_ready = 1'b1;
        step();
        chk("fl_dropped", occ, 0);

        // hold with one word
        clr = 1'b1;
        step();
        clr     = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h31;
        step();
        s_valid = 1'b0;
        hold    = 1'b1;
        step();
        step();
        step();
        chk("hold_m_valid", m_valid, 0);
        chk("hold_data", m_data, 64'h31);
        chk("hold_cnt", cnt, 3);
        hold = 1'b0;
        #1;
        chk("hold_release_valid", m_valid, 1);
        step();
        chk("hold_delivered", occ, 0);

        // saturation and clear-with-stall
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h41;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", cnt, 15);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_with_stall", cnt, 0);
        step();
        chk("cnt_after_clr", cnt, 1);
        m_ready = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {$urandom, $urandom};
            m_ready = ($urandom_range(0, 2) != 0);
            hold    = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            step();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        clr     = 1'b0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
